// File: rtl/reindeer_instruction_decode_pkg.sv
// ---------------------------------------------------------------------------
// reindeer_instruction_decode_pkg : shared widths, opcodes, class bits, states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reindeer_instruction_decode_pkg;

  localparam int XLEN        = 32;
  localparam int PC_BITWIDTH = 32;
  localparam int NUM_CLASSES = 11;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam int CLS_LOAD     = 0;
  localparam int CLS_STORE    = 1;
  localparam int CLS_BRANCH   = 2;
  localparam int CLS_JAL      = 3;
  localparam int CLS_JALR     = 4;
  localparam int CLS_LUI      = 5;
  localparam int CLS_AUIPC    = 6;
  localparam int CLS_OP       = 7;
  localparam int CLS_OP_IMM   = 8;
  localparam int CLS_SYSTEM   = 9;
  localparam int CLS_MISC_MEM = 10;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  typedef struct packed {
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [2:0]             funct3;
    logic                   funct7_b5;
    logic [XLEN-1:0]        imm;
    logic [NUM_CLASSES-1:0] cls;
    logic                   illegal;
  } dec_fields_t;

endpackage

`default_nettype wire

// File: rtl/reindeer_instruction_decode_if.sv
// ---------------------------------------------------------------------------
// reindeer_instruction_decode_if : fetch-side inputs and decoded outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface reindeer_instruction_decode_if
  import reindeer_instruction_decode_pkg::*;
  ();

  logic                   enable_in;
  logic [XLEN-1:0]        IR_in;
  logic [PC_BITWIDTH-1:0] PC_in;
  logic                   stall_in;
  logic                   flush_in;
  logic                   sync_reset;

  logic                   decode_valid_out;
  logic [PC_BITWIDTH-1:0] PC_out;
  logic [XLEN-1:0]        IR_out;
  logic [4:0]             rs1_out;
  logic [4:0]             rs2_out;
  logic [4:0]             rd_out;
  logic [2:0]             funct3_out;
  logic                   funct7_b5_out;
  logic [XLEN-1:0]        imm_out;
  logic [NUM_CLASSES-1:0] class_out;
  logic                   illegal_instr_out;
  logic                   fetch_next_out;
  logic                   overflow_out;

  modport master (
    output enable_in, IR_in, PC_in, stall_in, flush_in, sync_reset,
    input  decode_valid_out, PC_out, IR_out, rs1_out, rs2_out, rd_out,
           funct3_out, funct7_b5_out, imm_out, class_out, illegal_instr_out,
           fetch_next_out, overflow_out
  );

  modport slave (
    input  enable_in, IR_in, PC_in, stall_in, flush_in, sync_reset,
    output decode_valid_out, PC_out, IR_out, rs1_out, rs2_out, rd_out,
           funct3_out, funct7_b5_out, imm_out, class_out, illegal_instr_out,
           fetch_next_out, overflow_out
  );

endinterface

`default_nettype wire

// File: rtl/reindeer_instruction_decode_fields.sv
// ---------------------------------------------------------------------------
// reindeer_instruction_decode_fields : combinational IR -> fields/imm/class
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reindeer_instruction_decode_fields
  import reindeer_instruction_decode_pkg::*;
(
  input  logic [XLEN-1:0] i_ir,
  output dec_fields_t     o_fields
);

  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
  assign w_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
  assign w_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
  assign w_imm_u = {i_ir[31:12], 12'b0};
  assign w_imm_j = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};

  always_comb begin
    o_fields           = '0;
    o_fields.rs1       = i_ir[19:15];
    o_fields.rs2       = i_ir[24:20];
    o_fields.rd        = i_ir[11:7];
    o_fields.funct3    = i_ir[14:12];
    o_fields.funct7_b5 = i_ir[30];
    // Full 7-bit compare also rejects IR[1:0] != 2'b11.
    case (i_ir[6:0])
      OPC_LOAD:     begin o_fields.cls[CLS_LOAD]     = 1'b1; o_fields.imm = w_imm_i; end
      OPC_STORE:    begin o_fields.cls[CLS_STORE]    = 1'b1; o_fields.imm = w_imm_s; end
      OPC_BRANCH:   begin o_fields.cls[CLS_BRANCH]   = 1'b1; o_fields.imm = w_imm_b; end
      OPC_JAL:      begin o_fields.cls[CLS_JAL]      = 1'b1; o_fields.imm = w_imm_j; end
      OPC_JALR:     begin o_fields.cls[CLS_JALR]     = 1'b1; o_fields.imm = w_imm_i; end
      OPC_LUI:      begin o_fields.cls[CLS_LUI]      = 1'b1; o_fields.imm = w_imm_u; end
      OPC_AUIPC:    begin o_fields.cls[CLS_AUIPC]    = 1'b1; o_fields.imm = w_imm_u; end
      OPC_OP:       begin o_fields.cls[CLS_OP]       = 1'b1; end
      OPC_OP_IMM:   begin o_fields.cls[CLS_OP_IMM]   = 1'b1; o_fields.imm = w_imm_i; end
      OPC_SYSTEM:   begin o_fields.cls[CLS_SYSTEM]   = 1'b1; o_fields.imm = w_imm_i; end
      OPC_MISC_MEM: begin o_fields.cls[CLS_MISC_MEM] = 1'b1; o_fields.imm = w_imm_i; end
      default:      begin o_fields.illegal           = 1'b1; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reindeer_instruction_decode.sv
// ---------------------------------------------------------------------------
// reindeer_instruction_decode : 1-cycle decode stage with one-entry skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reindeer_instruction_decode
  import reindeer_instruction_decode_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  reindeer_instruction_decode_if.slave  bus
);

  logic [1:0]             r_state, w_next;
  dec_fields_t            r_fields, w_fields;
  logic [XLEN-1:0]        r_ir, r_skid_ir, w_src_ir;
  logic [PC_BITWIDTH-1:0] r_pc, r_skid_pc, w_src_pc;
  logic                   r_fetch, r_overflow;
  logic                   w_accept, w_kill;
  logic                   w_load_out, w_from_skid, w_load_skid, w_drop;

  assign w_accept = (r_state != S_EMPTY) && !bus.stall_in;
  assign w_kill   = bus.flush_in || bus.sync_reset;

  always_comb begin
    w_next      = r_state;
    w_load_out  = 1'b0;
    w_from_skid = 1'b0;
    w_load_skid = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (bus.enable_in) begin
          w_next     = S_VALID;
          w_load_out = 1'b1;
        end
      end
      S_VALID: begin
        if (bus.enable_in && bus.stall_in) begin
          w_load_skid = 1'b1;
          w_next      = S_FULL;
        end else if (bus.enable_in) begin
          w_load_out = 1'b1;
        end else if (!bus.stall_in) begin
          w_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (!bus.stall_in) begin
          w_load_out  = 1'b1;
          w_from_skid = 1'b1;
          w_load_skid = bus.enable_in;
          w_next      = bus.enable_in ? S_FULL : S_VALID;
        end else if (bus.enable_in) begin
          w_drop = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  // Single decoder: skid entry always has priority when it drains.
  assign w_src_ir = w_from_skid ? r_skid_ir : bus.IR_in;
  assign w_src_pc = w_from_skid ? r_skid_pc : bus.PC_in;

  reindeer_instruction_decode_fields u_fields (
    .i_ir     (w_src_ir),
    .o_fields (w_fields)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_fields   <= '0;
      r_ir       <= '0;
      r_pc       <= '0;
      r_skid_ir  <= '0;
      r_skid_pc  <= '0;
      r_fetch    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_kill) begin
      r_state <= S_EMPTY;
      r_fetch <= 1'b0;
      if (bus.sync_reset) r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fetch <= w_accept && (w_next != S_FULL);
      if (w_load_out) begin
        r_fields <= w_fields;
        r_ir     <= w_src_ir;
        r_pc     <= w_src_pc;
      end
      if (w_load_skid) begin
        r_skid_ir <= bus.IR_in;
        r_skid_pc <= bus.PC_in;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.decode_valid_out  = (r_state != S_EMPTY);
  assign bus.PC_out            = r_pc;
  assign bus.IR_out            = r_ir;
  assign bus.rs1_out           = r_fields.rs1;
  assign bus.rs2_out           = r_fields.rs2;
  assign bus.rd_out            = r_fields.rd;
  assign bus.funct3_out        = r_fields.funct3;
  assign bus.funct7_b5_out     = r_fields.funct7_b5;
  assign bus.imm_out           = r_fields.imm;
  assign bus.class_out         = r_fields.cls;
  assign bus.illegal_instr_out = bus.decode_valid_out && r_fields.illegal;
  assign bus.fetch_next_out    = r_fetch;
  assign bus.overflow_out      = r_overflow;

endmodule

`default_nettype wire

// File: doc/reindeer_instruction_decode.md
REINDEER_INSTRUCTION_DECODE -- requirements
Module: Reindeer_instruction_decode

Interface
REQ-001 SHALL: parameters from common.vh: XLEN = 32, PC_BITWIDTH = fetch PC width.
REQ-002 SHALL: clk  in  1  single clock.
REQ-003 SHALL: reset_n  in  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 SHALL: sync_reset  in  1  synchronous core restart; behaves as flush and also clears overflow_out.
REQ-005 SHALL: enable_in  in  1  one-cycle strobe from fetch; IR_in/PC_in valid this cycle.
REQ-006 SHALL: IR_in  in  XLEN  fetched instruction word.
REQ-007 SHALL: PC_in  in  PC_BITWIDTH  address of IR_in.
REQ-008 SHALL: stall_in  in  1  downstream (execute) not accepting.
REQ-009 SHALL: flush_in  in  1  discard all held instructions (branch/trap redirect).
REQ-010 SHALL: decode_valid_out  out  1  decoded fields valid; held while stalled.
REQ-011 SHALL: PC_out / IR_out  out  PC_BITWIDTH / XLEN  pass-through of the accepted instruction.
REQ-012 SHALL: rs1_out, rs2_out, rd_out  out  5 each  IR[19:15], IR[24:20], IR[11:7].
REQ-013 SHALL: funct3_out  out  3; funct7_b5_out  out  1 (IR[30]).
REQ-014 SHALL: imm_out  out  XLEN  sign-extended immediate for the decoded format.
REQ-015 SHALL: class_out  out  11  one-hot LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, SYSTEM, MISC_MEM.
REQ-016 SHALL: illegal_instr_out  out  1  opcode unsupported or IR[1:0] != 2'b11.
REQ-017 SHALL: fetch_next_out  out  1  one-cycle request to fetch for next instruction.
REQ-018 SHALL: overflow_out  out  1  sticky: instruction dropped because buffer full.

Function
REQ-019 SHALL: latency 1 cycle: enable_in at cycle N, not stalled, output empty or consumed -> decode_valid_out and all fields at N+1.
REQ-020 SHALL: accept = decode_valid_out & !stall_in; on accept with no new input and skid empty, decode_valid_out deasserts next cycle.
REQ-021 SHALL: FSM states S_EMPTY, S_VALID, S_FULL (output reg + one-entry skid holding raw IR/PC).
REQ-022 SHALL: S_EMPTY: enable_in -> S_VALID; else stay.
REQ-023 SHALL: S_VALID: enable_in & stall_in -> capture into skid, S_FULL; enable_in & !stall_in -> reload output, stay; !enable_in & !stall_in -> S_EMPTY.
REQ-024 SHALL: S_FULL: !stall_in -> skid decoded into output, S_VALID; enable_in in S_FULL -> instruction dropped, overflow_out set; accept and enable_in same cycle -> skid to output, new word to skid, stay S_FULL.
REQ-025 SHALL: fetch_next_out pulses cycle after each accept when resulting state is S_EMPTY or S_VALID; never in S_FULL.
REQ-026 SHALL: flush_in or sync_reset -> S_EMPTY next cycle, decode_valid_out = 0, enable_in same cycle ignored, no fetch_next_out pulse; flush wins over all other events.
REQ-027 SHALL: immediates: I = sext IR[31:20]; S = sext {IR[31:25],IR[11:7]}; B = sext {IR[31],IR[7],IR[30:25],IR[11:8],0}; U = {IR[31:12],12'b0}; J = sext {IR[31],IR[19:12],IR[20],IR[30:21],0}; R/other = 0.
REQ-028 SHALL: illegal instructions still produce decode_valid_out with class_out = 0 and illegal_instr_out = 1.
REQ-029 SHALL: fields with decode_valid_out = 0 are don't-care except illegal_instr_out = 0.

Reset
REQ-030 SHALL: reset_n low at a clk edge -> S_EMPTY, all outputs 0, skid cleared, regardless of in-flight state.
REQ-031 SHALL: first enable_in honoured on first edge with reset_n high.

Structure
REQ-032 SHALL: opcode constants, class one-hot indices, state encoding in shared package/header common.vh.
REQ-033 SHALL: combinational sub-module Reindeer_decode_fields (IR -> fields, imm, class, illegal), instantiated twice (input path, skid path) or once behind a mux.

Verification
REQ-034 SHALL: IR 0x00500093 PC 0x80 -> next cycle valid, rd=1, rs1=0, imm=0x5, class OP_IMM, fetch_next_out after accept.
REQ-035 SHALL: IR 0xFE208EE3 -> class BRANCH, rs1=1, rs2=2, imm=0xFFFFFFFC.
REQ-036 SHALL: stall_in high, two enable_in (0x00100093, 0x00200113) -> first held, second in skid; third enable_in -> overflow_out=1; release -> rd=1 then rd=2 in order.
REQ-037 SHALL: IR 0x00000000 -> valid, illegal_instr_out=1, class_out=0.
REQ-038 SHALL: S_FULL, flush_in together with enable_in -> next cycle valid=0, S_EMPTY, no fetch_next_out.
REQ-039 SHALL: reset_n low one cycle mid-S_FULL -> all outputs 0 next edge; overflow_out cleared.
